spi_mem_ctrl: RTL
=================

# spi_mem_ctrl

QSPI transaction engine between the CPU core and the shared SPI pins that feed the flash and RAM A chip selects. It accepts single-byte read/write requests over a valid/ready handshake and serialises each into a complete flash or PSRAM transaction: opcode, 24-bit address, mode/dummy cycles and data. It drives `spi_data_out`/`spi_data_oe`/`spi_clk_out`/`spi_flash_select`/`spi_ram_a_select` directly onto the top-level pin mapping and samples `spi_data_in`.

## Interface
- `ADDRESS_WIDTH`, 16, request address width (≤ 24); zero-extended to 24 bits on the wire
- `DATA_BUS_WIDTH`, 8, data width; fixed at 8 (two quad nibbles)
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller idle, will accept
- `req_write`  in  1  1 = write, 0 = read
- `req_target`  in  1  0 = flash, 1 = RAM A
- `req_address`  in  ADDRESS_WIDTH  byte address
- `req_wdata`  in  DATA_BUS_WIDTH  write data
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  DATA_BUS_WIDTH  read data, held until next read completes
- `spi_data_in`  in  4  IO3..IO0 from pins
- `spi_data_out`  out  4  IO3..IO0 to pins
- `spi_data_oe`  out  4  per-line output enable, 1 = drive
- `spi_clk_out`  out  1  SCK, idles low
- `spi_flash_select`  out  1  flash CS#, active low
- `spi_ram_a_select`  out  1  RAM A CS#, active low

## Operation
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, DESEL. All outputs registered.
- Handshake: accept when `req_valid && req_ready`; request fields latched that cycle. `req_ready`=1 only in IDLE and DESEL.
- Opcodes: flash read 0xEB, RAM read 0xEB, RAM write 0x38. Flash write: accepted, no CS asserted, `resp_valid` next cycle, `resp_rdata` unchanged.
- CMD: 8 SCK, opcode serial on IO0 MSB-first, oe=0001, IO3..1 out=0.
- ADDR: 6 SCK, 24-bit address quad, high nibble first, oe=1111.
- MODE (flash read only): 2 SCK, drive 0x00, oe=1111.
- DUMMY: flash 4 SCK, RAM read 6 SCK; oe=0000 from first DUMMY cycle.
- DATA: 2 SCK, high nibble first. Write: oe=1111 driving `req_wdata`. Read: oe=0000, sampled nibbles assemble into `resp_rdata`.
- SCK counts per transaction: flash read 22, RAM read 22, RAM write 16.
- DESEL: both CS# high, SCK low, oe=0000, `resp_valid`=1 one cycle; returns to IDLE, or starts next transaction if a request is accepted in DESEL.
- Only the selected chip's CS# ever goes low; never both.

## Timing
- SCK = clock/2. Each SCK = 2 clocks: phase 0 SCK low, data/oe update; phase 1 SCK high. Input sampled on the clock edge ending phase 1 (SCK falling).
- Accept at cycle T → CS# low and phase 0 of first CMD bit at T+1.
- Read: CS# low T+1..T+44, DESEL (CS# high, `resp_valid`, new `resp_rdata`) at T+45. Write: CS# low T+1..T+32, DESEL at T+33.
- Back-to-back: accept in DESEL cycle D → CS# low again D+1; minimum CS# high time 1 clock.
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0x00, `spi_clk_out`=0, `spi_data_out`=0, `spi_data_oe`=0, both CS# =1.
- Reset mid-transaction: outputs return to reset values immediately (asynchronous); transaction aborted, no `resp_valid`.
- `req_valid` while busy: ignored, no side effects; inputs may change freely.
- Address bits above ADDRESS_WIDTH on wire are 0.

## Test plan
- Reset asserted mid-ADDR of a RAM read → CS# high, SCK 0, oe 0000 same cycle; after release `req_ready`=1, no `resp_valid`.
- Flash read addr 0x1234, model returns 0xA5 → IO0 shows 0xEB over 8 SCK, nibbles 0,0,1,2,3,4, mode 0x00, 4 dummy; `resp_rdata`=0xA5, `resp_valid` at T+45, `spi_ram_a_select` stays 1.
- RAM write addr 0xFFFF data 0x3C → opcode 0x38, nibbles 0,0,F,F,F,F, then 3,C with oe=1111; DESEL at T+33; follow-up RAM read of 0xFFFF with 6 dummy returns 0x3C.
- Back-to-back: second request held valid during first read → accepted in DESEL cycle, CS# high exactly 1 clock, second response correct.
- Flash write request → no CS# activity, `resp_valid` at T+1, `resp_rdata` unchanged.
- Check per-cycle: `spi_data_oe` never 1111 during DUMMY/read DATA; SCK rising count matches 22/22/16.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// QSPI transaction engine: turns single-byte read/write requests into complete
// flash (0xEB quad read) or PSRAM (0xEB read / 0x38 write) transactions on shared pins.
module spi_mem_ctrl #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_target,
  input  logic [ADDRESS_WIDTH-1:0]  req_address,
  input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
  input  logic [3:0]                spi_data_in,
  output logic [3:0]                spi_data_out,
  output logic [3:0]                spi_data_oe,
  output logic                      spi_clk_out,
  output logic                      spi_flash_select,
  output logic                      spi_ram_a_select
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StMode, StDummy, StData, StDesel} state_e;

  state_e                    state_q, state_d;
  logic                      phase_q, phase_d;
  logic [2:0]                cnt_q, cnt_d;
  logic                      write_q, write_d;
  logic                      target_q, target_d;
  logic [23:0]               addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]                hi_nib_q, hi_nib_d;
  logic [DATA_BUS_WIDTH-1:0] rdata_q, rdata_d;

  logic       ready_q, ready_d;
  logic       resp_valid_q, resp_valid_d;
  logic       sck_q, sck_d;
  logic [3:0] dout_q, dout_d;
  logic [3:0] oe_q, oe_d;
  logic       fsel_q, fsel_d;
  logic       rsel_q, rsel_d;

  logic        accept;
  logic [2:0]  len_m1;
  state_e      state_after;
  logic [23:0] addr_ext;
  logic [7:0]  opcode;
  logic        active;

  always_comb begin
    addr_ext = '0;
    addr_ext[ADDRESS_WIDTH-1:0] = req_address;
  end

  // Per-state SCK count (minus one) and successor state.
  always_comb begin
    len_m1      = 3'd0;
    state_after = StDesel;
    case (state_q)
      StCmd: begin
        len_m1      = 3'd7;
        state_after = StAddr;
      end
      StAddr: begin
        len_m1 = 3'd5;
        if (write_q) begin
          state_after = StData;
        end else if (target_q) begin
          state_after = StDummy;
        end else begin
          state_after = StMode;
        end
      end
      StMode: begin
        len_m1      = 3'd1;
        state_after = StDummy;
      end
      StDummy: begin
        len_m1      = target_q ? 3'd5 : 3'd3;
        state_after = StData;
      end
      StData: begin
        len_m1      = 3'd1;
        state_after = StDesel;
      end
      default: begin
        len_m1      = 3'd0;
        state_after = StDesel;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    target_d = target_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hi_nib_d = hi_nib_q;
    rdata_d  = rdata_q;
    accept   = req_valid && ready_q;

    case (state_q)
      StIdle, StDesel: begin
        state_d = StIdle;
        if (accept) begin
          write_d  = req_write;
          target_d = req_target;
          addr_d   = addr_ext;
          wdata_d  = req_wdata;
          phase_d  = 1'b0;
          cnt_d    = 3'd0;
          // Flash has no write command: complete immediately without touching the bus.
          state_d  = (req_write && !req_target) ? StDesel : StCmd;
        end
      end
      default: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          // Read data is sampled on the edge that ends the SCK-high phase.
          if (state_q == StData && !write_q) begin
            if (cnt_q == 3'd0) begin
              hi_nib_d = spi_data_in;
            end else begin
              rdata_d = {hi_nib_q, spi_data_in};
            end
          end
          if (cnt_q == len_m1) begin
            cnt_d   = 3'd0;
            state_d = state_after;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
    endcase
  end

  // Pin values are decoded from next-state so every output comes straight from a flop.
  always_comb begin
    ready_d      = (state_d == StIdle) || (state_d == StDesel);
    resp_valid_d = (state_d == StDesel);
    active       = !ready_d;
    sck_d        = active && phase_d;
    fsel_d       = !(active && !target_d);
    rsel_d       = !(active && target_d);
    opcode       = write_d ? 8'h38 : 8'hEB;
    dout_d       = 4'h0;
    oe_d         = 4'h0;
    case (state_d)
      StCmd: begin
        dout_d = {3'b000, opcode[~cnt_d]};
        oe_d   = 4'b0001;
      end
      StAddr: begin
        oe_d = 4'hF;
        case (cnt_d)
          3'd0:    dout_d = addr_d[23:20];
          3'd1:    dout_d = addr_d[19:16];
          3'd2:    dout_d = addr_d[15:12];
          3'd3:    dout_d = addr_d[11:8];
          3'd4:    dout_d = addr_d[7:4];
          default: dout_d = addr_d[3:0];
        endcase
      end
      StMode: begin
        oe_d = 4'hF;
      end
      StData: begin
        if (write_d) begin
          oe_d   = 4'hF;
          dout_d = (cnt_d == 3'd0) ? wdata_d[7:4] : wdata_d[3:0];
        end
      end
      default: begin
        dout_d = 4'h0;
        oe_d   = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      cnt_q        <= 3'd0;
      write_q      <= 1'b0;
      target_q     <= 1'b0;
      addr_q       <= 24'h0;
      wdata_q      <= '0;
      hi_nib_q     <= 4'h0;
      rdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      sck_q        <= 1'b0;
      dout_q       <= 4'h0;
      oe_q         <= 4'h0;
      fsel_q       <= 1'b1;
      rsel_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      target_q     <= target_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hi_nib_q     <= hi_nib_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      sck_q        <= sck_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
      fsel_q       <= fsel_d;
      rsel_q       <= rsel_d;
    end
  end

  assign req_ready        = ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;
  assign spi_clk_out      = sck_q;
  assign spi_data_out     = dout_q;
  assign spi_data_oe      = oe_q;
  assign spi_flash_select = fsel_q;
  assign spi_ram_a_select = rsel_q;

endmodule
